// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_scheduler
//  Function : Time-multiplexed FIR controller. One shared multiply-accumulate
//             walks all taps, one per clock, for each accepted sample.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler #(
    parameter int WORD_IN = 8,
    parameter int COEF_W  = 8,
    parameter int TAPS    = 16,
    parameter int ACC_W   = WORD_IN + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WORD_IN-1:0]       data_in_i,
    input  logic                     coef_we_i,
    input  logic [$clog2(TAPS)-1:0]  coef_addr_i,
    input  logic [COEF_W-1:0]        coef_data_i,
    output logic [ACC_W-1:0]         data_out_o,
    output logic                     out_valid_o,
    output logic                     busy_o
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = WORD_IN + COEF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      k_q, k_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   data_out_q, data_out_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_IN-1:0] hist_q [TAPS];
    logic [COEF_W-1:0]  coef_q [TAPS];

    logic               hist_we;
    logic               coef_wr;
    logic [AW-1:0]      rd_idx;
    logic [PW-1:0]      prod;

    // Newest sample sits at wr_ptr; tap k reads k samples back, wrapping.
    assign rd_idx = wr_ptr_q - k_q;
    assign prod   = PW'(coef_q[k_q]) * PW'(hist_q[rd_idx]);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        hist_we     = 1'b0;
        coef_wr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                coef_wr = coef_we_i;
                if (in_valid_i) begin
                    hist_we = 1'b1;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                k_d   = k_q + AW'(1);
                if (k_q == AW'(TAPS - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                data_out_d  = acc_q;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + AW'(1);
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            if (hist_we) begin
                hist_q[wr_ptr_q] <= data_in_i;
            end
            if (coef_wr) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign data_out_o  = data_out_q;
    assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Time-multiplexed controller for the lowpass FIR path. It accepts one input sample per handshake and stores it in a circular history buffer. It then computes one filter output by running a single shared multiplier-accumulator across all taps, one tap per clock. Coefficients are loaded at run time through a write port. The block sits between the sample source (ADC/decimator side) and the downstream consumer of filter outputs. It replaces a fully parallel tap array when the system clock is much faster than the sample rate.

## Interface
- WORD_IN, 8, input sample width (unsigned)
- COEF_W, 8, coefficient width (unsigned)
- TAPS, 16, number of taps (power of two, ≥2)
- ACC_W, WORD_IN+COEF_W+$clog2(TAPS) (=20), accumulator / output width
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  Data_in is valid
- in_ready  out  1  block can accept a sample; high only in IDLE
- Data_in  in  WORD_IN  input sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index k
- coef_data  in  COEF_W  coefficient value h[k]
- Data_out  out  ACC_W  filter output y[n] = Σ h[k]·x[n−k], k=0..TAPS−1
- out_valid  out  1  one-cycle pulse, Data_out updated
- busy  out  1  high in MAC and DONE states

## Operation
- FSM with three states: IDLE, MAC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: buf[wr_ptr]<=Data_in, acc<=0, k<=0, state goes to MAC.
- MAC:
  - Each cycle, acc <= acc + coef[k]*buf[(wr_ptr−k) mod TAPS], then k<=k+1.
  - After the accumulation with k=TAPS−1, state goes to DONE.
- DONE:
  - Data_out<=acc, out_valid<=1, wr_ptr<=wr_ptr+1 (wraps TAPS−1→0), state goes to IDLE.
- History: buf holds the last TAPS accepted samples. Samples older than the buffer depth are overwritten. Before TAPS samples have arrived, the missing history reads as 0 (cleared at reset).
- Arithmetic:
  - All operations are unsigned. Products are COEF_W+WORD_IN bits, zero-extended to ACC_W.
  - With default widths, no overflow is possible (max 16·255·255=1040400 < 2^20).
  - If ACC_W is overridden smaller, the accumulator wraps modulo 2^ACC_W with no saturation.
- Coefficient writes:
  - Accepted only while state==IDLE; coef[coef_addr]<=coef_data.
  - coef_we in MAC or DONE is ignored. There is no error flag.
- Simultaneous coef_we and input handshake in IDLE: both take effect. The new coefficient is used for that sample's computation.
- Data_out holds its value between out_valid pulses.
- Reset (asserted low, any time):
  - state=IDLE, wr_ptr=0, k=0, acc=0.
  - All buf entries=0, all coef entries=0.
  - Data_out=0, out_valid=0, busy=0, in_ready=1 (combinational from state).
  - Any computation in progress is aborted with no out_valid.

## Timing
- The handshake is sampled at rising edge E0.
- MAC accumulations occur at edges E1..E_TAPS.
- The DONE register update occurs at edge E_TAPS+1.
- out_valid is high for exactly the cycle between E_TAPS+1 and E_TAPS+2.
- Latency from handshake edge to out_valid rise is TAPS+1 cycles (17 at default).
- in_ready is low from E0 through E_TAPS+1. The next handshake is possible at E_TAPS+2.
- Maximum throughput is one sample per TAPS+2 cycles (18). With in_valid held high continuously, handshakes occur every 18 cycles.
- in_ready is a combinational function of state only. It does not depend on in_valid.
- busy=1 exactly while in_ready=0.
- The sample source must hold Data_in stable while in_valid=1 and in_ready=0.

## Test plan
- Reset:
  - Stimulus: assert reset low mid-stream, then release.
  - Required: Data_out=0, out_valid=0, busy=0, in_ready=1.
  - Required: the first output after release with coef all 0 is 0.
- Impulse response:
  - Stimulus: load coef[k]=k+1; feed 1 followed by 17 zeros.
  - Required: outputs are 1,2,3,…,16, then 0, 0.
- Step response:
  - Stimulus: load coef all 1; feed 255 twenty times.
  - Required: outputs are 255,510,…,4080 (16th output), then 4080 held.
- Full-scale input:
  - Stimulus: load coef all 255; feed 255 sixteen times.
  - Required: 16th output is 1040400 with no wrap.
- Back-to-back handshakes:
  - Stimulus: hold in_valid=1 continuously.
  - Required: handshakes 18 cycles apart; each out_valid is a single-cycle pulse 17 cycles after its handshake.
  - Required: in_ready is low for exactly 17 cycles after each handshake.
- Coefficient-write guard and abort:
  - Stimulus: write coef[0]=9 while busy, then pulse reset at k=5 of a MAC pass.
  - Required: the write is ignored, no out_valid is produced for the aborted sample, and the next output equals h[0]·x with zero history.
